// File: rtl/fp32_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_multiplier
//  Purpose  : Registered IEEE-754 binary32 multiplier, round-to-nearest-even.
//             Denormal operands read as zero. Results below min normal are
//             flushed to signed zero. Single-cycle latency.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   rising-edge clock
//    rst        in   1   synchronous active-high reset
//    in_valid   in   1   a/b valid this cycle
//    a, b       in   32  binary32 operands
//    out_valid  out  1   result/flags valid (one cycle after in_valid)
//    result     out  32  binary32 product
//    invalid    out  1   NaN produced (NaN operand or Inf x 0)
//    overflow   out  1   finite product rounded above max normal -> +/-Inf
//    underflow  out  1   nonzero product below min normal -> +/-0
// ============================================================================
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [31:0] c_qnan    = 32'hFFC0_0000;
    localparam logic [7:0]  c_exp_max = 8'hFF;

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_sign;
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;

    assign w_ea     = a[30:23];
    assign w_eb     = b[30:23];
    assign w_fa     = a[22:0];
    assign w_fb     = b[22:0];
    assign w_sign   = a[31] ^ b[31];

    // exp == 0 is zero whatever the fraction holds (no denormal support)
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_a_inf  = (w_ea == c_exp_max) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == c_exp_max) && (w_fb == 23'd0);
    assign w_a_nan  = (w_ea == c_exp_max) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == c_exp_max) && (w_fb != 23'd0);

    // ------------------------------------------------------------------
    // Normal datapath
    // ------------------------------------------------------------------
    logic        [47:0] w_prod;
    logic signed [9:0]  w_exp_sum;
    logic signed [9:0]  w_exp_norm;
    logic signed [9:0]  w_exp_fin;
    logic        [23:0] w_mant;
    logic               w_guard, w_round, w_sticky, w_round_up;
    logic        [24:0] w_mant_rnd;
    logic        [22:0] w_frac_fin;

    assign w_prod    = {1'b1, w_fa} * {1'b1, w_fb};

    // Biased sum spans -125..381, so 10 signed bits cover it with margin
    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

    // Product of two [1,2) mantissas lies in [1,4); bit 47 marks [2,4)
    assign w_exp_norm = w_exp_sum + $signed({9'd0, w_prod[47]});
    assign w_mant     = w_prod[47] ? w_prod[47:24] : w_prod[46:23];
    assign w_guard    = w_prod[47] ? w_prod[23]    : w_prod[22];
    assign w_round    = w_prod[47] ? w_prod[22]    : w_prod[21];
    assign w_sticky   = w_prod[47] ? (|w_prod[21:0]) : (|w_prod[20:0]);

    // Ties (guard set, nothing below) go to the even mantissa
    assign w_round_up = w_guard & (w_round | w_sticky | w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + {24'd0, w_round_up};

    // Rounding carry-out means the mantissa became exactly 2.0
    assign w_exp_fin  = w_exp_norm + $signed({9'd0, w_mant_rnd[24]});
    assign w_frac_fin = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

    // ------------------------------------------------------------------
    // Result selection: specials first, in priority order
    // ------------------------------------------------------------------
    logic [31:0] w_result;
    logic        w_invalid, w_overflow, w_underflow;

    always_comb begin
        w_result    = 32'd0;
        w_invalid   = 1'b0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_result  = c_qnan;
            w_invalid = 1'b1;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_result  = c_qnan;
            w_invalid = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_result = {w_sign, c_exp_max, 23'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_result = {w_sign, 8'd0, 23'd0};
        end else if (w_exp_fin >= 10'sd255) begin
            w_result   = {w_sign, c_exp_max, 23'd0};
            w_overflow = 1'b1;
        end else if (w_exp_fin <= 10'sd0) begin
            w_result    = {w_sign, 8'd0, 23'd0};
            w_underflow = 1'b1;
        end else begin
            w_result = {w_sign, w_exp_fin[7:0], w_frac_fin};
        end
    end

    // ------------------------------------------------------------------
    // Output register: data/flags load only on in_valid, hold otherwise
    // ------------------------------------------------------------------
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_invalid, r_overflow, r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result    <= w_result;
                r_invalid   <= w_invalid;
                r_overflow  <= w_overflow;
                r_underflow <= w_underflow;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign invalid   = r_invalid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fp32_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_multiplier
//  Purpose  : Scoreboard bench for fp32_multiplier. A driver pushes the
//             reference-model answer for each accepted operand pair; a
//             negedge monitor pops and compares, and checks hold/reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_multiplier;

    typedef struct packed {
        logic [31:0] r;
        logic        inv;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;
    logic        invalid, overflow, underflow;

    fp32_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: exact integer product, rounded by remainder compare
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic        s;
        int          ex, ey, k, sh, ee;
        logic        xz, yz, xi, yi, xn, yn;
        longint unsigned p, q, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);            yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        e  = '0;
        if (xn || yn)                    begin e.r = 32'hFFC00000; e.inv = 1'b1; end
        else if ((xi && yz) || (yi && xz)) begin e.r = 32'hFFC00000; e.inv = 1'b1; end
        else if (xi || yi)               e.r = {s, 8'hFF, 23'd0};
        else if (xz || yz)               e.r = {s, 31'd0};
        else begin
            p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
            k = 63;
            while (p[k] == 1'b0) k--;
            sh   = k - 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            // value = p * 2^(ex+ey-254-46); leading one at bit k
            ee = ex + ey - 127 + (k - 46);
            if (q == (64'd1 << 24)) begin q = q >> 1; ee++; end
            if (ee >= 255)      begin e.r = {s, 8'hFF, 23'd0}; e.ovf = 1'b1; end
            else if (ee <= 0)   begin e.r = {s, 31'd0};        e.unf = 1'b1; end
            else                e.r = {s, 8'(ee), q[22:0]};
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       v[30:23] = 8'd0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3, 4:    v[30:23] = 8'($urandom_range(1, 8));
            5, 6:    v[30:23] = 8'($urandom_range(240, 254));
            7:       v[22:0] = 23'($urandom_range(0, 3));
            default: v[30:23] = 8'($urandom_range(60, 194));
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic exp_v   = 1'b0;
    logic exp_rst = 1'b0;
    exp_t last    = '0;

    always @(posedge clk) begin
        exp_v   <= in_valid && !rst;
        exp_rst <= rst;
    end

    always @(negedge clk) begin
        exp_t got, want;
        got = '{r: result, inv: invalid, ovf: overflow, unf: underflow};
        if (exp_rst) begin
            check("reset_valid", 64'(out_valid), 64'd0);
            check("reset_data", 64'(got), 64'd0);
            last = '0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    want = sb_q.pop_front();
                    check("product", 64'(got), 64'(want));
                    last = want;
                end
            end else begin
                check("hold", 64'(got), 64'(last));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic apply(input logic [31:0] x, input logic [31:0] y);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        sb_q.push_back(model(x, y));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] dir_a[] = '{
        32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F800000,
        32'hC1200000, 32'hC2480000, 32'hBF800000, 32'h42C80000,
        32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F800000,
        32'h7F800000, 32'h00000000, 32'h7FC00001, 32'h7F000000,
        32'h00800000, 32'h00000001, 32'h3F800001, 32'h3F800001
    };
    logic [31:0] dir_b[] = '{
        32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
        32'h41200000, 32'hC1C00000, 32'h3F800000, 32'h3EAAAAAB,
        32'h40000000, 32'h40000000, 32'h7F800000, 32'hFF800000,
        32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000,
        32'h3F000000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF
    };

    // Known answers from the test plan, checked against the model so a
    // model error cannot hide behind matching DUT output.
    logic [31:0] dir_r[] = '{
        32'h40000000, 32'h40C00000, 32'h3FC00000, 32'h3F800000,
        32'hC2C80000, 32'h44960000, 32'hBF800000, 32'h42055556,
        32'h7F800000, 32'hFF800000, 32'h7F800000, 32'hFF800000,
        32'hFFC00000, 32'h00000000, 32'hFFC00000, 32'h7F800000,
        32'h00000000, 32'h00000000
    };

    initial begin
        exp_t m;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < dir_r.size(); i++) begin
            m = model(dir_a[i], dir_b[i]);
            check("model_known", 64'(m.r), 64'(dir_r[i]));
        end

        // Directed vectors back-to-back
        for (int i = 0; i < dir_a.size(); i++) apply(dir_a[i], dir_b[i]);
        idle(3);

        // Reset with in_valid high; the pair in flight is discarded
        apply(32'h40400000, 32'h40400000);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h40000000;
        b        = 32'h40000000;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Randomized traffic with occasional bubbles
        for (int i = 0; i < 400; i++) begin
            apply(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        check("drain", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
